sdram_read: RTL and testbench

SDRAM_READ -- requirements
Module: sdram_read

---
 rtl/sdram_read.sv | 164 ++++++++++++++++
 tb/tb_sdram_read.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_read.sv
// sdram_read: single-bank SDRAM read sequencer (ACT, READ with auto-precharge, burst capture).
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module sdram_read #(
  parameter int CAS_LAT   = 2,
  parameter int BURST_LEN = 4
) (
  input  logic        iclk,
  input  logic        ireset,
  input  logic        ireq,
  input  logic        ienb,
  input  logic [12:0] irow,
  input  logic [9:0]  icolumn,
  input  logic [1:0]  ibank,
  output logic [15:0] odata,
  output logic        ovalid,
  output logic [2:0]  oidx,
  output logic        ofin,
  output logic        obusy,
  output logic        DRAM_CLK,
  output logic        DRAM_CKE,
  output logic [12:0] DRAM_ADDR,
  output logic [1:0]  DRAM_BA,
  output logic        DRAM_CS_N,
  output logic        DRAM_RAS_N,
  output logic        DRAM_CAS_N,
  output logic        DRAM_WE_N,
  output logic        DRAM_UDQM,
  output logic        DRAM_LDQM,
  input  logic [15:0] DRAM_DQ
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ACT      = 3'd1,
    S_NOP1     = 3'd2,
    S_READ     = 3'd3,
    S_CAS_WAIT = 3'd4,
    S_CAPTURE  = 3'd5,
    S_NOP2     = 3'd6,
    S_FIN      = 3'd7
  } state_t;

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [2:0] WORD_LAST = 3'(BURST_LEN - 1);
  localparam logic [1:0] CAS_LAST  = 2'(CAS_LAT - 1);

  state_t      state;
  logic [3:0]  cmd;
  logic [12:0] addr;
  logic [1:0]  ba;
  logic [1:0]  dqm;
  logic [1:0]  wait_cnt;
  logic [2:0]  word_cnt;
  logic [12:0] row_lat;
  logic [9:0]  col_lat;
  logic [1:0]  bank_lat;

  // Bus registers are loaded from the state held during the cycle, so every
  // command appears on the pins one clock after the FSM enters its state.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state    <= S_IDLE;
      cmd      <= CMD_NOP;
      addr     <= 13'd0;
      ba       <= 2'd0;
      dqm      <= 2'b11;
      odata    <= 16'd0;
      oidx     <= 3'd0;
      ovalid   <= 1'b0;
      ofin     <= 1'b0;
      obusy    <= 1'b0;
      wait_cnt <= 2'd0;
      word_cnt <= 3'd0;
      row_lat  <= 13'd0;
      col_lat  <= 10'd0;
      bank_lat <= 2'd0;
    end else begin
      cmd    <= CMD_NOP;
      addr   <= 13'd0;
      ba     <= 2'd0;
      dqm    <= 2'b11;
      ovalid <= 1'b0;
      ofin   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ireq) begin
            row_lat  <= irow;
            col_lat  <= icolumn;
            bank_lat <= ibank;
            obusy    <= 1'b1;
            state    <= S_ACT;
          end
        end
        S_ACT: begin
          cmd   <= CMD_ACT;
          addr  <= row_lat;
          ba    <= bank_lat;
          state <= S_NOP1;
        end
        S_NOP1: state <= S_READ;
        S_READ: begin
          cmd      <= CMD_READ;
          addr     <= {3'b001, col_lat};
          ba       <= bank_lat;
          dqm      <= 2'b00;
          wait_cnt <= 2'd0;
          state    <= S_CAS_WAIT;
        end
        S_CAS_WAIT: begin
          dqm <= 2'b00;
          if (wait_cnt == CAS_LAST) begin
            word_cnt <= 3'd0;
            state    <= S_CAPTURE;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        S_CAPTURE: begin
          dqm    <= 2'b00;
          odata  <= DRAM_DQ;
          oidx   <= word_cnt;
          ovalid <= 1'b1;
          if (word_cnt == WORD_LAST) begin
            wait_cnt <= 2'd0;
            state    <= S_NOP2;
          end else begin
            word_cnt <= word_cnt + 3'd1;
          end
        end
        S_NOP2: begin
          if (wait_cnt == 2'd1) begin
            ofin  <= 1'b1;
            obusy <= 1'b0;
            state <= S_FIN;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus release tri-states every SDRAM pin; internal sequencing is unaffected.
  assign DRAM_CLK   = ienb ? ~iclk  : 1'bz;
  assign DRAM_CKE   = ienb ? 1'b1   : 1'bz;
  assign DRAM_ADDR  = ienb ? addr   : 13'bz;
  assign DRAM_BA    = ienb ? ba     : 2'bz;
  assign DRAM_CS_N  = ienb ? cmd[3] : 1'bz;
  assign DRAM_RAS_N = ienb ? cmd[2] : 1'bz;
  assign DRAM_CAS_N = ienb ? cmd[1] : 1'bz;
  assign DRAM_WE_N  = ienb ? cmd[0] : 1'bz;
  assign DRAM_UDQM  = ienb ? dqm[1] : 1'bz;
  assign DRAM_LDQM  = ienb ? dqm[0] : 1'bz;

endmodule

`default_nettype wire

// File: tb/tb_sdram_read.sv
// tb_sdram_read: three parameterisations of sdram_read checked against a timeline model.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_sdram_read;
  localparam int NI = 3;
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_READ = 4'b0101;

  function automatic int cl_of(input int i);
    return (i == 1) ? 3 : 2;
  endfunction
  function automatic int bl_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 1 : 8);
  endfunction

  logic        clk = 1'b0;
  logic        rst, req, enb;
  logic [12:0] row;
  logic [9:0]  col;
  logic [1:0]  bank;
  logic [15:0] dq;

  wire [15:0] odata_w [NI];
  wire        ovalid_w [NI];
  wire [2:0]  oidx_w [NI];
  wire        ofin_w [NI];
  wire        obusy_w [NI];
  wire [3:0]  cmd_w [NI];
  wire [12:0] addr_w [NI];
  wire [1:0]  ba_w [NI];
  wire [1:0]  dqm_w [NI];
  wire        cke_w [NI];
  wire        dclk_w [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    wire cs_l, ras_l, cas_l, we_l, cke_l, clk_l, udqm_l, ldqm_l;
    wire [12:0] addr_l;
    wire [1:0]  ba_l;
    pullup   pu_cs  (cs_l);
    pulldown pd_cke (cke_l);
    sdram_read #(.CAS_LAT(cl_of(g)), .BURST_LEN(bl_of(g))) u_dut (
      .iclk(clk), .ireset(rst), .ireq(req), .ienb(enb),
      .irow(row), .icolumn(col), .ibank(bank),
      .odata(odata_w[g]), .ovalid(ovalid_w[g]), .oidx(oidx_w[g]),
      .ofin(ofin_w[g]), .obusy(obusy_w[g]),
      .DRAM_CLK(clk_l), .DRAM_CKE(cke_l), .DRAM_ADDR(addr_l), .DRAM_BA(ba_l),
      .DRAM_CS_N(cs_l), .DRAM_RAS_N(ras_l), .DRAM_CAS_N(cas_l), .DRAM_WE_N(we_l),
      .DRAM_UDQM(udqm_l), .DRAM_LDQM(ldqm_l), .DRAM_DQ(dq)
    );
    assign cmd_w[g]  = {cs_l, ras_l, cas_l, we_l};
    assign addr_w[g] = addr_l;
    assign ba_w[g]   = ba_l;
    assign dqm_w[g]  = {udqm_l, ldqm_l};
    assign cke_w[g]  = cke_l;
    assign dclk_w[g] = clk_l;
  end

  // Reference model: per instance, the accept edge k and the latched request;
  // every output is a function of d = edge - k.
  int          n, checks, errors;
  bit          act_m [NI];
  int          k_m [NI];
  int          free_m [NI];
  logic [12:0] row_m [NI];
  logic [9:0]  col_m [NI];
  logic [1:0]  bank_m [NI];
  logic [15:0] data_m [NI];
  logic [2:0]  idx_m [NI];
  logic [15:0] base, base0;

  int          act_cnt, fin_edge;
  logic [12:0] act_addr, rd_addr;
  logic [1:0]  act_ba;
  logic [15:0] words[$];
  logic [2:0]  idxs[$];
  int          act_edges[$];

  typedef struct {
    logic [12:0] row;
    logic [9:0]  col;
    logic [1:0]  bank;
    logic [15:0] base;
    logic [12:0] exp_act;
    logic [1:0]  exp_ba;
    logic [12:0] exp_rd;
    int          exp_fin;
  } vec_t;
  vec_t vecs [3];

  task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d edge %0d: got 0x%0h expected 0x%0h", name, i, n, got, exp);
    end
  endtask

  task automatic model_edge();
    n++;
    for (int i = 0; i < NI; i++) begin
      int d;
      if (rst) begin
        act_m[i]  = 1'b0;
        data_m[i] = 16'd0;
        idx_m[i]  = 3'd0;
        free_m[i] = n;
      end else begin
        d = n - k_m[i];
        if (act_m[i] && d >= 4 + cl_of(i) && d <= 3 + cl_of(i) + bl_of(i)) begin
          data_m[i] = dq;
          idx_m[i]  = 3'(d - 4 - cl_of(i));
        end
        if (req && n >= free_m[i]) begin
          act_m[i]  = 1'b1;
          k_m[i]    = n;
          free_m[i] = n + cl_of(i) + bl_of(i) + 7;
          row_m[i]  = row;
          col_m[i]  = col;
          bank_m[i] = bank;
          if (i == 0) base0 = base;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      int cl, bl, d;
      logic [3:0]  ecmd;
      logic [12:0] eaddr;
      logic [1:0]  eba, edqm;
      cl = cl_of(i);
      bl = bl_of(i);
      d  = act_m[i] ? (n - k_m[i]) : -100;
      ecmd = CMD_NOP; eaddr = 13'd0; eba = 2'd0; edqm = 2'b11;
      if (d == 1) begin ecmd = CMD_ACT; eaddr = row_m[i]; eba = bank_m[i]; end
      if (d == 3) begin ecmd = CMD_READ; eaddr = {3'b001, col_m[i]}; eba = bank_m[i]; end
      if (d >= 3 && d <= 3 + cl + bl) edqm = 2'b00;
      chk("ovalid", i, ovalid_w[i], (d >= 4 + cl && d <= 3 + cl + bl) ? 1 : 0);
      chk("ofin", i, ofin_w[i], (d == 5 + cl + bl) ? 1 : 0);
      chk("obusy", i, obusy_w[i], (d >= 0 && d <= 4 + cl + bl) ? 1 : 0);
      chk("odata", i, odata_w[i], data_m[i]);
      chk("oidx", i, oidx_w[i], idx_m[i]);
      if (enb) begin
        chk("cmd", i, cmd_w[i], ecmd);
        chk("addr", i, addr_w[i], eaddr);
        chk("ba", i, ba_w[i], eba);
        chk("dqm", i, dqm_w[i], edqm);
        chk("cke", i, cke_w[i], 1);
        chk("dram_clk", i, dclk_w[i], 1);
      end else begin
        chk("cs_n_released", i, cmd_w[i][3], 1);
        chk("cke_released", i, cke_w[i], 0);
      end
    end
  endtask

  task automatic observe();
    if (enb && cmd_w[0] == CMD_ACT) begin
      act_cnt++;
      act_addr = addr_w[0];
      act_ba   = ba_w[0];
      act_edges.push_back(n);
    end
    if (enb && cmd_w[0] == CMD_READ) rd_addr = addr_w[0];
    if (ovalid_w[0]) begin
      words.push_back(odata_w[0]);
      idxs.push_back(oidx_w[0]);
    end
    if (ofin_w[0]) fin_edge = n;
  endtask

  task automatic cycle();
    int d;
    dq = 16'($urandom);
    d  = n + 1 - k_m[0];
    if (act_m[0] && d >= 4 + cl_of(0) && d <= 3 + cl_of(0) + bl_of(0))
      dq = base0 + 16'(d - 4 - cl_of(0));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    observe();
  endtask

  task automatic clear_obs();
    act_cnt = 0; fin_edge = -1; act_addr = '0; rd_addr = '0; act_ba = '0;
    words.delete(); idxs.delete(); act_edges.delete();
  endtask

  task automatic reset_check();
    for (int i = 0; i < NI; i++) begin
      chk("rst_ovalid", i, ovalid_w[i], 0);
      chk("rst_ofin", i, ofin_w[i], 0);
      chk("rst_obusy", i, obusy_w[i], 0);
      chk("rst_odata", i, odata_w[i], 0);
      chk("rst_oidx", i, oidx_w[i], 0);
      chk("rst_cmd", i, cmd_w[i], CMD_NOP);
      chk("rst_addr", i, addr_w[i], 0);
      chk("rst_ba", i, ba_w[i], 0);
      chk("rst_dqm", i, dqm_w[i], 2'b11);
    end
  endtask

  task automatic request(input logic [12:0] r, input logic [9:0] c, input logic [1:0] b,
                         input logic [15:0] bs, output int k);
    row = r; col = c; bank = b; base = bs; req = 1'b1;
    k = n + 1;
    cycle();
    req  = 1'b0;
    row  = 13'($urandom);
    col  = 10'($urandom);
    bank = 2'($urandom);
  endtask

  task automatic check_txn(input string name, input int k, input logic [15:0] bs, input int fin_ofs);
    chk({name, "_words"}, 0, words.size(), 4);
    for (int j = 0; j < words.size() && j < 8; j++) begin
      chk({name, "_data"}, 0, words[j], bs + 16'(j));
      chk({name, "_idx"}, 0, idxs[j], j);
    end
    chk({name, "_fin_ofs"}, 0, fin_edge - k, fin_ofs);
  endtask

  initial begin
    int k;
    checks = 0; errors = 0; n = 0;
    rst = 1'b1; req = 1'b0; enb = 1'b1;
    row = '0; col = '0; bank = '0; dq = '0; base = '0; base0 = '0;
    for (int i = 0; i < NI; i++) begin
      act_m[i] = 1'b0; k_m[i] = 0; free_m[i] = 0; data_m[i] = '0; idx_m[i] = '0;
      row_m[i] = '0; col_m[i] = '0; bank_m[i] = '0;
    end
    clear_obs();
    vecs[0] = '{13'h0123, 10'h045, 2'd2, 16'hA000, 13'h0123, 2'd2, 13'h0445, 11};
    vecs[1] = '{13'h1FFF, 10'h3FF, 2'd3, 16'h5A00, 13'h1FFF, 2'd3, 13'h07FF, 11};
    vecs[2] = '{13'h0000, 10'h000, 2'd0, 16'hFFFC, 13'h0000, 2'd0, 13'h0400, 11};

    #1;
    reset_check();
    @(negedge clk);
    repeat (2) cycle();
    rst = 1'b0;
    repeat (3) cycle();

    for (int v = 0; v < 3; v++) begin
      clear_obs();
      request(vecs[v].row, vecs[v].col, vecs[v].bank, vecs[v].base, k);
      repeat (24) cycle();
      chk("vec_act_count", v, act_cnt, 1);
      chk("vec_act_addr", v, act_addr, vecs[v].exp_act);
      chk("vec_act_ba", v, act_ba, vecs[v].exp_ba);
      chk("vec_read_addr", v, rd_addr, vecs[v].exp_rd);
      check_txn("vec", k, vecs[v].base, vecs[v].exp_fin);
    end

    // Second request during a busy transaction, different address.
    clear_obs();
    request(13'h0AAA, 10'h155, 2'd1, 16'h1230, k);
    repeat (4) cycle();
    row = 13'h1555; col = 10'h2AA; bank = 2'd2; req = 1'b1;
    cycle();
    req = 1'b0;
    repeat (20) cycle();
    chk("collide_act_count", 0, act_cnt, 1);
    chk("collide_act_addr", 0, act_addr, 13'h0AAA);
    check_txn("collide", k, 16'h1230, 11);

    // Asynchronous reset after the second captured word.
    clear_obs();
    request(13'h0042, 10'h011, 2'd3, 16'hB000, k);
    for (int t = 0; t < 30 && words.size() < 2; t++) cycle();
    chk("pre_reset_words", 0, words.size(), 2);
    rst = 1'b1;
    #1;
    reset_check();
    cycle();
    cycle();
    rst = 1'b0;
    clear_obs();
    repeat (20) cycle();
    chk("post_reset_words", 0, words.size(), 0);
    chk("post_reset_fin", 0, fin_edge, -1);
    clear_obs();
    request(13'h0777, 10'h0CC, 2'd1, 16'hC000, k);
    repeat (24) cycle();
    check_txn("after_reset", k, 16'hC000, 11);

    // Bus released from edge k+2 through k+6.
    clear_obs();
    request(13'h0314, 10'h159, 2'd0, 16'hD000, k);
    cycle();
    enb = 1'b0;
    repeat (5) cycle();
    enb = 1'b1;
    repeat (20) cycle();
    chk("release_act_count", 0, act_cnt, 1);
    check_txn("release", k, 16'hD000, 11);

    // Request held high: back-to-back transactions restart from idle.
    clear_obs();
    row = 13'h0100; col = 10'h020; bank = 2'd1; base = 16'hE000; req = 1'b1;
    repeat (40) cycle();
    req = 1'b0;
    repeat (20) cycle();
    chk("held_act_count", 0, act_edges.size(), 4);
    if (act_edges.size() >= 2) chk("held_act_gap", 0, act_edges[1] - act_edges[0], 13);

    for (int t = 0; t < 800; t++) begin
      req  = ($urandom_range(0, 2) == 0);
      row  = 13'($urandom);
      col  = 10'($urandom);
      bank = 2'($urandom);
      base = 16'($urandom);
      enb  = ($urandom_range(0, 9) != 0);
      rst  = ($urandom_range(0, 149) == 0);
      cycle();
    end
    rst = 1'b0; enb = 1'b1; req = 1'b0;
    repeat (20) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
